// File: rtl/blake512_pkg.sv
// Shared constants, tables and helpers for the BLAKE-512 round sequencer.
// Word i of a 1024-bit bus sits at [1023-64i -: 64]; word 0 is the MSB word.
package blake512_pkg;

  localparam int NUM_G  = 2;
  localparam int WORD_W = 64;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

  localparam logic [0:15][WORD_W-1:0] C = '{
    64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
    64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
    64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
    64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69
  };

  // One permutation per row, entry 0 in the top nibble.
  localparam logic [0:9][63:0] SIGMA = '{
    64'h0123456789ABCDEF, 64'hEA489FD61C02B753, 64'hB8C052FDAE367194, 64'h7931DCBE265A40F8,
    64'h905724AFE1BC683D, 64'h2C6A0B834D75FE19, 64'hC51FED4A0763928B, 64'hDB7EC13950F4862A,
    64'h6FE9B308C2D714A5, 64'hA2847615FB9E3CD0
  };

  // Per step: v indices for a1 b1 c1 d1 a2 b2 c2 d2 (top nibble first).
  // Columns for steps 0/1, diagonals for steps 2/3.
  localparam logic [0:3][31:0] OP_MAP = '{
    32'h048C159D, 32'h26AE37BF, 32'h05AF16BC, 32'h278D349E
  };

  function automatic logic [WORD_W-1:0] word(input logic [1023:0] v, input logic [3:0] i);
    return v[1023 - 64*int'(i) -: 64];
  endfunction

  function automatic logic [3:0] sigma_row(input logic [3:0] round);
    return (round >= 4'd10) ? round - 4'd10 : round;
  endfunction

  function automatic logic [3:0] sigma_idx(input logic [3:0] row, input logic [3:0] k);
    return SIGMA[row][63 - 4*int'(k) -: 4];
  endfunction

  function automatic logic [3:0] op_idx(input logic [1:0] step, input logic [2:0] k);
    return OP_MAP[step][31 - 4*int'(k) -: 4];
  endfunction

endpackage

// File: rtl/blake_g_operand_select.sv
// Combinational read mux: picks a/b/c/d for both G units of a step from v.
// Mirrors the write-back mapping used by the state-update block.
module blake_g_operand_select
  import blake512_pkg::*;
(
  input  logic [1023:0]                         v_state,
  input  logic [1:0]                            step,
  output logic [NUM_G-1:0][3:0][WORD_W-1:0]     ops
);

  for (genvar g = 0; g < NUM_G; g++) begin : g_unit
    for (genvar k = 0; k < 4; k++) begin : g_opnd
      assign ops[g][k] = word(v_state, op_idx(step, 3'(g*4 + k)));
    end
  end

endmodule

// File: rtl/blake_round_sequencer.sv
// Read side of the BLAKE-512 compression loop: alternates FETCH (register
// operands and message^constant words) and EXEC (one state-update strobe).
module blake_round_sequencer
  import blake512_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1023:0] m_block,
  input  logic [1023:0] v_state,
  output logic          busy,
  output logic          done,
  output logic [5:0]    counter_idx,
  output logic          op_valid,
  output logic          upd_en,
  output logic [63:0]   a1_out,
  output logic [63:0]   b1_out,
  output logic [63:0]   c1_out,
  output logic [63:0]   d1_out,
  output logic [63:0]   a2_out,
  output logic [63:0]   b2_out,
  output logic [63:0]   c2_out,
  output logic [63:0]   d2_out,
  output logic [63:0]   mc0_1,
  output logic [63:0]   mc1_1,
  output logic [63:0]   mc0_2,
  output logic [63:0]   mc1_2
);

  localparam logic [5:0] LAST_IDX = 6'(4*ROUNDS - 1);

  state_t                               state, state_nxt;
  logic [1023:0]                        msg;
  logic [5:0]                           idx;
  logic [3:0]                           row;
  logic                                 accept;
  logic [NUM_G-1:0][3:0][WORD_W-1:0]    ops_sel, ops_q;
  logic [NUM_G-1:0][1:0][WORD_W-1:0]    mc_sel, mc_q;

  assign accept = (state == S_IDLE) && start;
  assign row    = sigma_row(idx[5:2]);

  blake_g_operand_select u_sel (
    .v_state (v_state),
    .step    (idx[1:0]),
    .ops     (ops_sel)
  );

  // G index gi = 2*step + g selects sigma entries 2gi and 2gi+1.
  for (genvar g = 0; g < NUM_G; g++) begin : g_mc
    logic [3:0] s0, s1;
    assign s0 = sigma_idx(row, {idx[1:0], 1'(g), 1'b0});
    assign s1 = sigma_idx(row, {idx[1:0], 1'(g), 1'b1});
    assign mc_sel[g][0] = word(msg, s0) ^ C[s1];
    assign mc_sel[g][1] = word(msg, s1) ^ C[s0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC:  state_nxt = (idx == LAST_IDX) ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg   <= '0;
      idx   <= '0;
      ops_q <= '0;
      mc_q  <= '0;
    end else begin
      if (accept) begin
        msg <= m_block;
        idx <= '0;
      end
      if (state == S_FETCH) begin
        ops_q <= ops_sel;
        mc_q  <= mc_sel;
      end
      // Counter stays at the last index through DONE; only a new start clears it.
      if (state == S_EXEC && idx != LAST_IDX) idx <= idx + 6'd1;
    end
  end

  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign done        = (state == S_DONE);
  assign op_valid    = (state == S_EXEC);
  assign upd_en      = (state == S_EXEC);
  assign counter_idx = idx;

  assign a1_out = ops_q[0][0];
  assign b1_out = ops_q[0][1];
  assign c1_out = ops_q[0][2];
  assign d1_out = ops_q[0][3];
  assign a2_out = ops_q[1][0];
  assign b2_out = ops_q[1][1];
  assign c2_out = ops_q[1][2];
  assign d2_out = ops_q[1][3];
  assign mc0_1  = mc_q[0][0];
  assign mc1_1  = mc_q[0][1];
  assign mc0_2  = mc_q[1][0];
  assign mc1_2  = mc_q[1][1];

endmodule

// File: tb/tb_blake_round_sequencer.sv
// Directed bench for blake_round_sequencer: operand/mc vectors plus timing,
// start-filtering, message-latch and mid-run reset sequences.
module tb_blake_round_sequencer;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1023:0] m_block = '0;
  logic [1023:0] v_state = '0;
  logic          busy, done, op_valid, upd_en;
  logic [5:0]    counter_idx;
  logic [63:0]   a1_out, b1_out, c1_out, d1_out, a2_out, b2_out, c2_out, d2_out;
  logic [63:0]   mc0_1, mc1_1, mc0_2, mc1_2;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [63:0] K0  = 64'h243F6A8885A308D3, K1  = 64'h13198A2E03707344;
  localparam logic [63:0] K2  = 64'hA4093822299F31D0, K3  = 64'h082EFA98EC4E6C89;
  localparam logic [63:0] K8  = 64'h9216D5D98979FB1B, K9  = 64'hD1310BA698DFB5AC;
  localparam logic [63:0] K10 = 64'h2FFD72DBD01ADFB7, K11 = 64'hB8E1AFED6A267E96;
  localparam logic [63:0] K12 = 64'hBA7C9045F12C7F99, K13 = 64'h24A19947B3916CF7;
  localparam logic [63:0] K14 = 64'h0801F2E2858EFC16, K15 = 64'h636920D871574E69;

  typedef struct packed {
    logic         m_seq;  // 1: m_j = j, 0: m = 0
    logic [5:0]   idx;
    logic [31:0]  ops;    // expected v indices a1..d2, a1 in top nibble
    logic [255:0] mc;     // {mc0_1, mc1_1, mc0_2, mc1_2}
  } vec_t;

  vec_t vecs[6];

  blake_round_sequencer #(.ROUNDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .m_block(m_block), .v_state(v_state),
    .busy(busy), .done(done), .counter_idx(counter_idx), .op_valid(op_valid), .upd_en(upd_en),
    .a1_out(a1_out), .b1_out(b1_out), .c1_out(c1_out), .d1_out(d1_out),
    .a2_out(a2_out), .b2_out(b2_out), .c2_out(c2_out), .d2_out(d2_out),
    .mc0_1(mc0_1), .mc1_1(mc1_1), .mc0_2(mc0_2), .mc1_2(mc1_2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [1023:0] seq_words();
    logic [1023:0] r;
    for (int i = 0; i < 16; i++) r[1023 - 64*i -: 64] = 64'(i);
    return r;
  endfunction

  function automatic logic [511:0] ops_exp(input logic [31:0] nib);
    logic [511:0] r;
    for (int k = 0; k < 8; k++) r[511 - 64*k -: 64] = {60'd0, nib[31 - 4*k -: 4]};
    return r;
  endfunction

  function automatic logic [511:0] ops_act();
    return {a1_out, b1_out, c1_out, d1_out, a2_out, b2_out, c2_out, d2_out};
  endfunction

  function automatic logic [255:0] mc_act();
    return {mc0_1, mc1_1, mc0_2, mc1_2};
  endfunction

  task automatic wait_exec(input logic [5:0] idx, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (op_valid && counter_idx == idx) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!busy && !done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(nm, 512'(ok), 512'(1));
  endtask

  initial begin
    bit ok;
    int n, pulses, consec, first_upd, last_upd, done_n, done_cnt;
    logic prev_upd, busy129, busy130, busy131;
    logic [5:0] done_idx, idx131;
    logic [255:0] mc40;

    vecs[0] = '{m_seq: 1'b0, idx: 6'd0,  ops: 32'h048C159D, mc: {K1, K0, K3, K2}};
    vecs[1] = '{m_seq: 1'b0, idx: 6'd2,  ops: 32'h05AF16BC, mc: {K9, K8, K11, K10}};
    vecs[2] = '{m_seq: 1'b0, idx: 6'd3,  ops: 32'h278D349E, mc: {K13, K12, K15, K14}};
    vecs[3] = '{m_seq: 1'b1, idx: 6'd4,  ops: 32'h048C159D,
                mc: {64'h2FFD72DBD01ADFB9, 64'h0801F2E2858EFC1C, 64'h9216D5D98979FB1F, 64'h452821E638D0137F}};
    vecs[4] = '{m_seq: 1'b1, idx: 6'd40, ops: 32'h048C159D,
                mc: {K1, 64'h243F6A8885A308D2, 64'h082EFA98EC4E6C8B, 64'hA4093822299F31D3}};
    vecs[5] = '{m_seq: 1'b1, idx: 6'd63, ops: 32'h278D349E,
                mc: {64'h0801F2E2858EFC19, 64'h636920D871574E67, 64'hD1310BA698DFB5AD, 64'h13198A2E0370734D}};

    v_state = seq_words();

    // Reset state
    #2;
    chk("reset_ctrl", 512'({busy, done, op_valid, upd_en, counter_idx}), 512'(0));
    chk("reset_ops", ops_act(), 512'(0));
    chk("reset_mc", 512'(mc_act()), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven operand and mc vectors
    for (int i = 0; i < 6; i++) begin
      m_block = vecs[i].m_seq ? seq_words() : '0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_exec(vecs[i].idx, ok);
      chk($sformatf("vec%0d_reach", i), 512'(ok), 512'(1));
      chk($sformatf("vec%0d_ops", i), ops_act(), ops_exp(vecs[i].ops));
      chk($sformatf("vec%0d_mc", i), 512'(mc_act()), 512'(vecs[i].mc));
      wait_idle($sformatf("vec%0d_idle", i));
    end

    // Timing: start held high throughout, m_block disturbed mid-run
    m_block = seq_words();
    pulses = 0; consec = 0; first_upd = -1; last_upd = -1; done_n = -1; done_cnt = 0;
    prev_upd = 1'b0; done_idx = '0; mc40 = '0;
    busy129 = 1'bx; busy130 = 1'bx; busy131 = 1'bx; idx131 = 'x;
    @(negedge clk); start = 1'b1;
    for (n = 1; n <= 131; n++) begin
      @(negedge clk);
      if (n == 20) m_block = ~seq_words();
      if (upd_en) begin
        pulses++;
        if (prev_upd) consec++;
        if (first_upd < 0) first_upd = n;
        last_upd = n;
      end
      prev_upd = upd_en;
      if (done) begin
        done_cnt++;
        done_n = n;
        done_idx = counter_idx;
      end
      if (op_valid && counter_idx == 6'd40 && n < 129) mc40 = mc_act();
      if (n == 129) busy129 = busy;
      if (n == 130) busy130 = busy;
      if (n == 131) begin
        busy131 = busy;
        idx131 = counter_idx;
      end
    end
    start = 1'b0;
    chk("upd_pulses", 512'(pulses), 512'(64));
    chk("upd_consecutive", 512'(consec), 512'(0));
    chk("first_upd_cycle", 512'(first_upd), 512'(2));
    chk("last_upd_cycle", 512'(last_upd), 512'(128));
    chk("done_cycle", 512'(done_n), 512'(129));
    chk("done_count", 512'(done_cnt), 512'(1));
    chk("done_idx", 512'(done_idx), 512'(63));
    chk("busy_in_done", 512'(busy129), 512'(0));
    chk("busy_idle_130", 512'(busy130), 512'(0));
    chk("restart_busy_131", 512'(busy131), 512'(1));
    chk("restart_idx_131", 512'(idx131), 512'(0));
    chk("mc_latched_msg", 512'(mc40), 512'(vecs[4].mc));
    wait_idle("timing_idle");

    // Reset in cycle 57 of a compression, then a clean full run
    m_block = seq_words();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (n = 2; n <= 57; n++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 512'({busy, done, op_valid, upd_en, counter_idx}), 512'(0));
    chk("midrst_ops", ops_act(), 512'(0));
    chk("midrst_mc", 512'(mc_act()), 512'(0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); start = 1'b1;
    pulses = 0; done_n = -1;
    for (n = 1; n <= 135; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (upd_en) pulses++;
      if (done && done_n < 0) done_n = n;
    end
    chk("rerun_pulses", 512'(pulses), 512'(64));
    chk("rerun_done_cycle", 512'(done_n), 512'(129));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
